// File: rtl/bcd_pkg.sv
// Shared BCD nibble constants and helpers for the down counter and its digit cells.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return is_bcd(nibble) ? nibble : BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle of the BCD down counter; master drives enable and load, slave is the counter.
interface bcd_down_counter_if #(
    parameter int DIGITS = 2
) ();

    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic                  zero;
    logic                  tc;
    logic                  wrap_p;
    logic                  load_err;

    modport master (
        output en, load, load_val,
        input  q, zero, tc, wrap_p, load_err
    );

    modport slave (
        input  en, load, load_val,
        output q, zero, tc, wrap_p, load_err
    );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit cell: loads a clamped nibble or decrements 0 -> 9 on a borrow.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ld_digit,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       is_zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= BCD_ZERO;
        end else if (load) begin
            digit <= bcd_clamp(ld_digit);
        end else if (dec) begin
            digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign is_zero = (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down counter with wrap or saturate at zero,
// combinational zero/terminal-count and registered wrap/load-error pulses.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_down_counter_if.slave    bus
);

    localparam bit WRAP_EN = (WRAP != 0);

    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] dec;
    logic              all_zero;
    logic              step;
    logic              lower_zero;
    logic              any_bad;

    assign all_zero = &is_zero;
    // In saturate mode the step at all-zero is suppressed so no digit borrows to 9.
    assign step     = bus.en & ~bus.load & (WRAP_EN | ~all_zero);

    always_comb begin
        dec        = '0;
        lower_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            dec[k]     = step & lower_zero;
            lower_zero = lower_zero & is_zero[k];
        end
    end

    always_comb begin
        any_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            any_bad = any_bad | ~is_bcd(bus.load_val[4*k +: 4]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .load     (bus.load),
            .ld_digit (bus.load_val[4*g +: 4]),
            .dec      (dec[g]),
            .digit    (bus.q[4*g +: 4]),
            .is_zero  (is_zero[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wrap_p   <= 1'b0;
            bus.load_err <= 1'b0;
        end else if (bus.load) begin
            bus.wrap_p   <= 1'b0;
            bus.load_err <= any_bad;
        end else begin
            bus.wrap_p   <= bus.en & all_zero;
            bus.load_err <= 1'b0;
        end
    end

    assign bus.zero = all_zero;
    assign bus.tc   = bus.en & all_zero;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: wrap and saturate variants plus a two-stage cascade.
module tb_bcd_down_counter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    bcd_down_counter_if #(.DIGITS(2)) bus_a ();
    bcd_down_counter_if #(.DIGITS(2)) bus_s ();
    bcd_down_counter_if #(.DIGITS(1)) bus_ca ();
    bcd_down_counter_if #(.DIGITS(1)) bus_cb ();

    bcd_down_counter #(.DIGITS(2), .WRAP(1)) dut     (.clk(clk), .rst(rst), .bus(bus_a));
    bcd_down_counter #(.DIGITS(2), .WRAP(0)) dut_sat (.clk(clk), .rst(rst), .bus(bus_s));
    bcd_down_counter #(.DIGITS(1), .WRAP(1)) dut_ca  (.clk(clk), .rst(rst), .bus(bus_ca));
    bcd_down_counter #(.DIGITS(1), .WRAP(1)) dut_cb  (.clk(clk), .rst(rst), .bus(bus_cb));

    assign bus_cb.en = bus_ca.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus_a.en = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus_a.q !== 8'h00) begin n_bad++; $display("FAIL reset_q: got %h expected 00", bus_a.q); end
        n_cmp++; if (bus_a.zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero: got %b expected 1", bus_a.zero); end
        n_cmp++; if (bus_a.tc !== 1'b1) begin n_bad++; $display("FAIL reset_tc: got %b expected 1", bus_a.tc); end
        n_cmp++; if (bus_a.wrap_p !== 1'b0) begin n_bad++; $display("FAIL reset_wrap_p: got %b expected 0", bus_a.wrap_p); end
        n_cmp++; if (bus_a.load_err !== 1'b0) begin n_bad++; $display("FAIL reset_load_err: got %b expected 0", bus_a.load_err); end
        n_cmp++; if (bus_s.q !== 8'h00) begin n_bad++; $display("FAIL reset_sat_q: got %h expected 00", bus_s.q); end
        bus_a.en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_count_wrap();
        logic [7:0] exp_q;
        bus_a.load = 1'b1;
        bus_a.load_val = 8'h42;
        tick();
        n_cmp++; if (bus_a.q !== 8'h42) begin n_bad++; $display("FAIL load_42_q: got %h expected 42", bus_a.q); end
        n_cmp++; if (bus_a.load_err !== 1'b0) begin n_bad++; $display("FAIL load_42_err: got %b expected 0", bus_a.load_err); end
        bus_a.load = 1'b0;
        bus_a.en = 1'b1;
        for (int i = 1; i <= 43; i++) begin
            tick();
            exp_q = (i <= 42) ? to_bcd(42 - i) : 8'h99;
            n_cmp++; if (bus_a.q !== exp_q) begin n_bad++; $display("FAIL count_q step %0d: got %h expected %h", i, bus_a.q, exp_q); end
            n_cmp++; if (bus_a.wrap_p !== (i == 43)) begin n_bad++; $display("FAIL count_wrap_p step %0d: got %b expected %b", i, bus_a.wrap_p, (i == 43)); end
            n_cmp++; if (bus_a.tc !== (i == 42)) begin n_bad++; $display("FAIL count_tc step %0d: got %b expected %b", i, bus_a.tc, (i == 42)); end
        end
        bus_a.en = 1'b0;
        tick();
        n_cmp++; if (bus_a.q !== 8'h99) begin n_bad++; $display("FAIL hold_q: got %h expected 99", bus_a.q); end
        n_cmp++; if (bus_a.wrap_p !== 1'b0) begin n_bad++; $display("FAIL wrap_p_clear: got %b expected 0", bus_a.wrap_p); end
        n_cmp++; if (bus_a.tc !== 1'b0) begin n_bad++; $display("FAIL hold_tc: got %b expected 0", bus_a.tc); end
    endtask

    task automatic test_load_clamp();
        bus_a.load = 1'b1;
        bus_a.load_val = 8'h3F;
        tick();
        n_cmp++; if (bus_a.q !== 8'h39) begin n_bad++; $display("FAIL clamp_3f_q: got %h expected 39", bus_a.q); end
        n_cmp++; if (bus_a.load_err !== 1'b1) begin n_bad++; $display("FAIL clamp_3f_err: got %b expected 1", bus_a.load_err); end
        bus_a.load = 1'b0;
        tick();
        n_cmp++; if (bus_a.load_err !== 1'b0) begin n_bad++; $display("FAIL clamp_err_pulse: got %b expected 0", bus_a.load_err); end
        n_cmp++; if (bus_a.q !== 8'h39) begin n_bad++; $display("FAIL clamp_hold_q: got %h expected 39", bus_a.q); end
        bus_a.load = 1'b1;
        bus_a.load_val = 8'hA0;
        tick();
        n_cmp++; if (bus_a.q !== 8'h90) begin n_bad++; $display("FAIL clamp_a0_q: got %h expected 90", bus_a.q); end
        n_cmp++; if (bus_a.load_err !== 1'b1) begin n_bad++; $display("FAIL clamp_a0_err: got %b expected 1", bus_a.load_err); end
        bus_a.load_val = 8'hFF;
        tick();
        n_cmp++; if (bus_a.q !== 8'h99) begin n_bad++; $display("FAIL clamp_ff_q: got %h expected 99", bus_a.q); end
        bus_a.load_val = 8'h57;
        tick();
        n_cmp++; if (bus_a.q !== 8'h57) begin n_bad++; $display("FAIL load_57_q: got %h expected 57", bus_a.q); end
        n_cmp++; if (bus_a.load_err !== 1'b0) begin n_bad++; $display("FAIL load_57_err: got %b expected 0", bus_a.load_err); end
        bus_a.load = 1'b0;
    endtask

    task automatic test_priority();
        bus_a.load = 1'b1;
        bus_a.en = 1'b1;
        bus_a.load_val = 8'h10;
        tick();
        n_cmp++; if (bus_a.q !== 8'h10) begin n_bad++; $display("FAIL load_over_en_q: got %h expected 10", bus_a.q); end
        rst = 1'b1;
        bus_a.load_val = 8'hAF;
        tick();
        n_cmp++; if (bus_a.q !== 8'h00) begin n_bad++; $display("FAIL rst_over_load_q: got %h expected 00", bus_a.q); end
        n_cmp++; if (bus_a.load_err !== 1'b0) begin n_bad++; $display("FAIL rst_over_load_err: got %b expected 0", bus_a.load_err); end
        rst = 1'b0;
        bus_a.load = 1'b0;
        bus_a.en = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        logic [7:0] exp_q [4];
        logic       exp_w [4];
        exp_q = '{8'h01, 8'h00, 8'h00, 8'h00};
        exp_w = '{1'b0, 1'b0, 1'b1, 1'b1};
        bus_s.load = 1'b1;
        bus_s.load_val = 8'h02;
        tick();
        n_cmp++; if (bus_s.q !== 8'h02) begin n_bad++; $display("FAIL sat_load_q: got %h expected 02", bus_s.q); end
        bus_s.load = 1'b0;
        bus_s.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus_s.q !== exp_q[i]) begin n_bad++; $display("FAIL sat_q step %0d: got %h expected %h", i, bus_s.q, exp_q[i]); end
            n_cmp++; if (bus_s.wrap_p !== exp_w[i]) begin n_bad++; $display("FAIL sat_wrap_p step %0d: got %b expected %b", i, bus_s.wrap_p, exp_w[i]); end
        end
        n_cmp++; if (bus_s.zero !== 1'b1) begin n_bad++; $display("FAIL sat_zero: got %b expected 1", bus_s.zero); end
        n_cmp++; if (bus_s.tc !== 1'b1) begin n_bad++; $display("FAIL sat_tc: got %b expected 1", bus_s.tc); end
        bus_s.en = 1'b0;
        tick();
        n_cmp++; if (bus_s.wrap_p !== 1'b0) begin n_bad++; $display("FAIL sat_wrap_clear: got %b expected 0", bus_s.wrap_p); end
    endtask

    task automatic test_cascade();
        bus_ca.load = 1'b1;
        bus_ca.load_val = 4'h0;
        bus_cb.load = 1'b1;
        bus_cb.load_val = 4'h1;
        tick();
        n_cmp++; if ({bus_cb.q, bus_ca.q} !== 8'h10) begin n_bad++; $display("FAIL casc_load: got %h expected 10", {bus_cb.q, bus_ca.q}); end
        bus_ca.load = 1'b0;
        bus_cb.load = 1'b0;
        bus_ca.en = 1'b1;
        tick();
        n_cmp++; if ({bus_cb.q, bus_ca.q} !== 8'h09) begin n_bad++; $display("FAIL casc_step1: got %h expected 09", {bus_cb.q, bus_ca.q}); end
        n_cmp++; if (bus_cb.tc !== 1'b0) begin n_bad++; $display("FAIL casc_b_tc: got %b expected 0", bus_cb.tc); end
        tick();
        n_cmp++; if ({bus_cb.q, bus_ca.q} !== 8'h08) begin n_bad++; $display("FAIL casc_step2: got %h expected 08", {bus_cb.q, bus_ca.q}); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({bus_cb.q, bus_ca.q} !== 8'h00) begin n_bad++; $display("FAIL casc_reset: got %h expected 00", {bus_cb.q, bus_ca.q}); end
        rst = 1'b0;
        bus_ca.en = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus_a.en = 1'b0;  bus_a.load = 1'b0;  bus_a.load_val = '0;
        bus_s.en = 1'b0;  bus_s.load = 1'b0;  bus_s.load_val = '0;
        bus_ca.en = 1'b0; bus_ca.load = 1'b0; bus_ca.load_val = '0;
        bus_cb.load = 1'b0; bus_cb.load_val = '0;

        test_reset();
        test_count_wrap();
        test_load_clamp();
        test_priority();
        test_saturate();
        test_cascade();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
